// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender for the MIPS decode stage.
// Extends a raw immediate in one of four modes when it is accepted, then
// carries the result and its tag through a two-entry valid/ready skid
// buffer. The buffer supports a synchronous flush and an asynchronous reset.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg
);

  // Branch mode shifts left by two, so two guard bits must exist above the field.
  if (OUT_W < IN_W + 2) begin : gen_width_check
    $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
  end

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e             state_q;
  logic [OUT_W-1:0]   head_data_q;
  logic [TAG_W-1:0]   head_tag_q;
  logic [OUT_W-1:0]   skid_data_q;
  logic [TAG_W-1:0]   skid_tag_q;

  logic [OUT_W-1:0]   sext;
  logic [OUT_W-1:0]   ext_data;
  logic               accept;
  logic               pop;

  // Extend the incoming immediate according to its mode.
  always_comb begin
    sext     = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
    ext_data = sext;
    unique case (in_mode)
      2'b00: ext_data = sext;
      2'b01: ext_data = {{(OUT_W-IN_W){1'b0}}, in_imm};
      2'b10: ext_data = {in_imm, {(OUT_W-IN_W){1'b0}}};
      2'b11: ext_data = sext << 2;
      default: ext_data = sext;
    endcase
  end

  // Handshake: in_ready depends only on registered state, flush and reset,
  // never on out_ready, so upstream sees no combinational path from downstream.
  always_comb begin
    in_ready  = !reset && !flush && (state_q != StFull);
    out_valid = (state_q != StEmpty);
    accept    = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  assign out_data = head_data_q;
  assign out_tag  = head_tag_q;
  assign out_neg  = head_data_q[OUT_W-1];

  // Buffer state machine: head drives the outputs, skid absorbs one extra
  // entry when downstream stalls. Data registers keep their value on empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StEmpty;
      head_data_q <= '0;
      head_tag_q  <= '0;
      skid_data_q <= '0;
      skid_tag_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            head_data_q <= ext_data;
            head_tag_q  <= in_tag;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (accept && pop) begin
            head_data_q <= ext_data;
            head_tag_q  <= in_tag;
          end else if (accept) begin
            skid_data_q <= ext_data;
            skid_tag_q  <= in_tag;
            state_q     <= StFull;
          end else if (pop) begin
            state_q <= StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_data_q <= skid_data_q;
            head_tag_q  <= skid_tag_q;
            state_q     <= StOne;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

endmodule
